// File: rtl/ifetch_unit.sv
// ============================================================================
// Module   : ifetch_unit
// Purpose  : Credit-limited instruction fetch with a 2-entry in-flight PC queue,
//            a 2-entry decode buffer and redirect-drop accounting.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [63:0] id_pc,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc
);

  logic [63:0] r_fetch_pc;
  logic [63:0] r_infl_pc [2];
  logic        r_infl_wr;
  logic        r_infl_rd;
  logic [1:0]  r_inflight;
  logic [1:0]  r_drop_cnt;
  logic [31:0] r_buf_instr [2];
  logic [63:0] r_buf_pc [2];
  logic        r_buf_wr;
  logic        r_buf_rd;
  logic [1:0]  r_count;

  logic [2:0]  w_occupancy;
  logic        w_req_fire;
  logic        w_rsp_take;
  logic        w_rsp_drop;
  logic        w_buf_push;
  logic        w_id_pop;

  // In-flight requests plus buffered words never exceed the buffer depth
  assign w_occupancy    = {1'b0, r_inflight} + {1'b0, r_count};
  assign imem_req_valid = reset_n && !redirect_valid && (w_occupancy < 3'd2);
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign w_rsp_take = imem_rsp_valid && (r_inflight != 2'd0);
  assign w_rsp_drop = w_rsp_take && (redirect_valid || (r_drop_cnt != 2'd0));
  assign w_buf_push = w_rsp_take && !w_rsp_drop;

  assign id_valid = reset_n && (r_count != 2'd0) && !redirect_valid;
  assign id_instr = r_buf_instr[r_buf_rd];
  assign id_pc    = r_buf_pc[r_buf_rd];
  assign w_id_pop = id_valid && id_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_pc <= RESET_PC;
      r_infl_wr  <= 1'b0;
      r_infl_rd  <= 1'b0;
      r_inflight <= 2'd0;
      r_drop_cnt <= 2'd0;
      r_buf_wr   <= 1'b0;
      r_buf_rd   <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      if (w_req_fire) r_infl_wr <= ~r_infl_wr;
      if (w_rsp_take) r_infl_rd <= ~r_infl_rd;
      r_inflight <= r_inflight + {1'b0, w_req_fire} - {1'b0, w_rsp_take};

      if (redirect_valid) begin
        r_fetch_pc <= {redirect_pc[63:2], 2'b00};
        // Everything still outstanding after this cycle's response is stale
        r_drop_cnt <= r_inflight - {1'b0, w_rsp_take};
        r_buf_wr   <= 1'b0;
        r_buf_rd   <= 1'b0;
        r_count    <= 2'd0;
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + 64'd4;
        if (w_rsp_drop) r_drop_cnt <= r_drop_cnt - 2'd1;
        if (w_buf_push) r_buf_wr <= ~r_buf_wr;
        if (w_id_pop)   r_buf_rd <= ~r_buf_rd;
        r_count <= r_count + {1'b0, w_buf_push} - {1'b0, w_id_pop};
      end
    end
  end

  // Payload storage carries no reset; validity is tracked by the counters above
  always_ff @(posedge clk) begin
    if (w_req_fire) r_infl_pc[r_infl_wr] <= r_fetch_pc;
    if (w_buf_push) begin
      r_buf_instr[r_buf_wr] <= imem_rsp_data;
      r_buf_pc[r_buf_wr]    <= r_infl_pc[r_infl_rd];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ifetch_unit.sv
// ============================================================================
// Module   : tb_ifetch_unit
// Purpose  : Scoreboard bench for ifetch_unit with an in-order memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifetch_unit;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } mem_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } id_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [63:0] id_pc;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'h0;

  always #5 clk = ~clk;

  ifetch_unit #(.RESET_PC(64'h0)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          mem_lat = 1;
  int          req_count = 0;
  logic [63:0] exp_req[$];
  id_t         exp_id[$];
  mem_t        mem_q[$];

  logic        drv_rst_n = 1'b0;
  logic        drv_id_ready = 1'b0;
  logic        drv_redirect = 1'b0;
  logic [63:0] drv_redirect_pc = 64'h0;
  logic        mem_spurious = 1'b0;

  // Memory model (drives responses at negedge) and monitor (samples at negedge+2)
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      if (mem_spurious) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
      end else if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hA000_0000 | {8'h00, mem_q[0].addr[23:0]};
        void'(mem_q.pop_front());
      end
      #2;
      if (!reset_n) begin
        mem_q.delete();
      end else begin
        if (imem_req_valid && imem_req_ready) begin
          mem_t m;
          req_count++;
          n_tests++;
          if (exp_req.size() == 0) begin
            n_fail++;
            $display("FAIL req_addr: unexpected request addr=%h", imem_req_addr);
          end else begin
            logic [63:0] e;
            e = exp_req.pop_front();
            if (imem_req_addr !== e) begin
              n_fail++;
              $display("FAIL req_addr: got %h expected %h", imem_req_addr, e);
            end
          end
          m.addr = imem_req_addr;
          m.due  = cyc + mem_lat;
          mem_q.push_back(m);
        end
        if (id_valid && id_ready) begin
          n_tests++;
          if (exp_id.size() == 0) begin
            n_fail++;
            $display("FAIL id_out: unexpected pc=%h instr=%h", id_pc, id_instr);
          end else begin
            id_t e;
            e = exp_id.pop_front();
            if (id_pc !== e.pc || id_instr !== e.instr) begin
              n_fail++;
              $display("FAIL id_out: got pc=%h instr=%h expected pc=%h instr=%h",
                       id_pc, id_instr, e.pc, e.instr);
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    reset_n        = drv_rst_n;
    id_ready       = drv_id_ready;
    redirect_valid = drv_redirect;
    redirect_pc    = drv_redirect_pc;
    imem_req_ready = (exp_req.size() != 0);
    #3;
  endtask

  task automatic exp_r(input logic [63:0] pc);
    exp_req.push_back(pc);
  endtask

  task automatic exp_i(input logic [63:0] pc, input logic [31:0] instr);
    id_t e;
    e.pc    = pc;
    e.instr = instr;
    exp_id.push_back(e);
  endtask

  task automatic do_reset();
    drv_rst_n    = 1'b0;
    drv_redirect = 1'b0;
    drv_id_ready = 1'b0;
    repeat (2) begin
      step();
      check("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
      check("rst_id_valid", {63'h0, id_valid}, 64'h0);
    end
    drv_rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && (exp_req.size() != 0 || exp_id.size() != 0); i++) step();
    check("drain_req_left", 64'(exp_req.size()), 64'h0);
    check("drain_id_left", 64'(exp_id.size()), 64'h0);
  endtask

  initial begin
    int base;

    // Streaming with a single-cycle memory
    do_reset();
    mem_lat = 1;
    drv_id_ready = 1'b1;
    exp_r(64'h0);  exp_r(64'h4);  exp_r(64'h8);  exp_r(64'hC);  exp_r(64'h10);
    exp_i(64'h0, 32'hA000_0000);  exp_i(64'h4, 32'hA000_0004);
    exp_i(64'h8, 32'hA000_0008);  exp_i(64'hC, 32'hA000_000C);
    exp_i(64'h10, 32'hA000_0010);
    drain();

    // Decode stalled for 10 cycles: only two requests, head held stable
    do_reset();
    exp_r(64'h0);  exp_r(64'h4);  exp_r(64'h8);
    exp_i(64'h0, 32'hA000_0000);  exp_i(64'h4, 32'hA000_0004);
    exp_i(64'h8, 32'hA000_0008);
    base = req_count;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i >= 3)
        check("stall_head", {id_valid, id_pc[30:0], id_instr},
              {1'b1, 31'h0, 32'hA000_0000});
    end
    check("stall_req_count", 64'(req_count - base), 64'd2);
    drv_id_ready = 1'b1;
    drain();

    // Two requests in flight, back-to-back redirects; last target wins
    do_reset();
    mem_lat = 3;
    drv_id_ready = 1'b1;
    exp_r(64'h0);  exp_r(64'h4);  exp_r(64'h8);  exp_r(64'hC);
    exp_i(64'h0, 32'hA000_0000);  exp_i(64'h4, 32'hA000_0004);
    for (int i = 0; i < 30 && exp_req.size() != 0; i++) step();
    drv_redirect = 1'b1;
    drv_redirect_pc = 64'h3000;
    step();
    check("redir_id_valid", {63'h0, id_valid}, 64'h0);
    drv_redirect_pc = 64'h1002;
    step();
    check("redir_req_valid", {63'h0, imem_req_valid}, 64'h0);
    drv_redirect = 1'b0;
    exp_r(64'h1000);  exp_r(64'h1004);
    exp_i(64'h1000, 32'hA000_1000);  exp_i(64'h1004, 32'hA000_1004);
    drain();

    // Redirect in the same cycle as a response with one word buffered
    do_reset();
    mem_lat = 1;
    exp_r(64'h0);  exp_r(64'h4);
    step();
    step();
    drv_redirect = 1'b1;
    drv_redirect_pc = 64'h2000;
    step();
    check("redir_rsp_id_valid", {63'h0, id_valid}, 64'h0);
    check("redir_rsp_req_valid", {63'h0, imem_req_valid}, 64'h0);
    drv_redirect = 1'b0;
    drv_id_ready = 1'b1;
    exp_r(64'h2000);  exp_r(64'h2004);
    exp_i(64'h2000, 32'hA000_2000);  exp_i(64'h2004, 32'hA000_2004);
    drain();

    // Address held while not accepted, then redirect wrapping past 2^64
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_req", {imem_req_valid, imem_req_addr[62:0]}, {1'b1, 63'h0});
    end
    drv_redirect = 1'b1;
    drv_redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    drv_redirect = 1'b0;
    drv_id_ready = 1'b1;
    exp_r(64'hFFFF_FFFF_FFFF_FFFC);  exp_r(64'h0);
    exp_i(64'hFFFF_FFFF_FFFF_FFFC, 32'hA0FF_FFFC);
    exp_i(64'h0, 32'hA000_0000);
    drain();

    // Reset with two in flight, then a spurious response right after release
    do_reset();
    mem_lat = 3;
    drv_id_ready = 1'b1;
    exp_r(64'h0);  exp_r(64'h4);
    repeat (3) step();
    do_reset();
    mem_lat = 1;
    drv_id_ready = 1'b1;
    exp_r(64'h0);  exp_r(64'h4);
    exp_i(64'h0, 32'hA000_0000);  exp_i(64'h4, 32'hA000_0004);
    mem_spurious = 1'b1;
    step();
    mem_spurious = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
